// File: rtl/spike_fifo_arb.sv
// Per-channel spike event FIFOs merged by a round-robin arbiter onto one stream.
// Define SPIKE_FIFO_DROP_CNT_EN to add per-channel saturating drop counters.
module spike_fifo_arb #(
   parameter int NCH   = 4,
   parameter int DEPTH = 256,
   parameter int M     = 8
) (
   input  logic                    CLK,
   input  logic                    RSTN,
   input  logic                    clear_i,
   input  logic [NCH-1:0]          w_en_i,
   input  logic [NCH*M-1:0]        w_data_i,
   output logic [NCH-1:0]          full_o,
   output logic [NCH-1:0]          empty_o,
   output logic [NCH-1:0]          overflow_o,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [M-1:0]            out_data_o,
   output logic [$clog2(NCH)-1:0]  out_ch_o
`ifdef SPIKE_FIFO_DROP_CNT_EN
   ,
   output logic [NCH*16-1:0]       drop_cnt_o
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(NCH);

   logic [M-1:0]   r_mem  [NCH][DEPTH];
   logic [AW:0]    r_wptr [NCH];
   logic [AW:0]    r_rptr [NCH];
   logic [CW-1:0]  r_last;
   logic [NCH-1:0] r_ovf;
   logic           r_valid;
   logic [M-1:0]   r_data;
   logic [CW-1:0]  r_ch;

   logic [NCH-1:0] w_full;
   logic [NCH-1:0] w_empty;
   logic [NCH-1:0] w_wr;
   logic [NCH-1:0] w_drop;
   logic [NCH-1:0] w_pop;
   logic           w_load;
   logic           w_gnt_vld;
   logic [CW-1:0]  w_gnt;
   int             w_idx;

   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         w_empty[k] = (r_wptr[k] == r_rptr[k]);
         w_full[k]  = (r_wptr[k][AW] != r_rptr[k][AW]) &&
                      (r_wptr[k][AW-1:0] == r_rptr[k][AW-1:0]);
      end
   end

   assign w_wr   = w_en_i & ~w_full;
   assign w_drop = w_en_i & w_full;
   assign w_load = !r_valid || out_ready_i;

   // Scan from farthest offset down so the nearest request after r_last wins.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt     = '0;
      w_idx     = 0;
      for (int i = NCH; i >= 1; i--) begin
         w_idx = (int'(r_last) + i) % NCH;
         if (!w_empty[w_idx[CW-1:0]]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = w_idx[CW-1:0];
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         w_pop[k] = w_load && w_gnt_vld && (w_gnt == CW'(k));
      end
   end

   always_ff @(posedge CLK) begin
      for (int k = 0; k < NCH; k++) begin
         if (w_wr[k]) begin
            r_mem[k][r_wptr[k][AW-1:0]] <= w_data_i[k*M +: M];
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         for (int k = 0; k < NCH; k++) begin
            r_wptr[k] <= '0;
            r_rptr[k] <= '0;
         end
         r_ovf <= '0;
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (w_wr[k]) r_wptr[k] <= r_wptr[k] + 1'b1;
            if (w_pop[k]) r_rptr[k] <= r_rptr[k] + 1'b1;
            if (w_drop[k]) r_ovf[k] <= 1'b1;
            else if (clear_i) r_ovf[k] <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_ch    <= '0;
         r_last  <= CW'(NCH - 1);
      end else if (w_load) begin
         r_valid <= w_gnt_vld;
         if (w_gnt_vld) begin
            r_data <= r_mem[w_gnt][r_rptr[w_gnt][AW-1:0]];
            r_ch   <= w_gnt;
            r_last <= w_gnt;
         end
      end
   end

   assign full_o      = w_full;
   assign empty_o     = w_empty;
   assign overflow_o  = r_ovf;
   assign out_valid_o = r_valid;
   assign out_data_o  = r_data;
   assign out_ch_o    = r_ch;

`ifdef SPIKE_FIFO_DROP_CNT_EN
   logic [15:0] r_cnt [NCH];

   // A drop in the clearing cycle still counts as the first new drop.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         for (int k = 0; k < NCH; k++) r_cnt[k] <= '0;
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (clear_i) r_cnt[k] <= {15'b0, w_drop[k]};
            else if (w_drop[k] && r_cnt[k] != 16'hFFFF)
               r_cnt[k] <= r_cnt[k] + 16'd1;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NCH; k++) drop_cnt_o[k*16 +: 16] = r_cnt[k];
   end
`endif

endmodule

// File: doc/spike_fifo_arb.md
# spike_fifo_arb

Multi-channel successor to the single spike FIFO: `NCH` independent event FIFOs, each `DEPTH` entries of `M` bits, merged onto one valid/ready output stream by a round-robin arbiter. It sits between the spike sources (input AER / core event outputs) and the neuron-update controller. Each output event carries its source channel ID. Writes to a full channel are dropped and flagged.

## Interface
- `NCH`, 4: number of input channels; ≥2.
- `DEPTH`, 256: entries per channel FIFO; power of two, ≥2.
- `M`, 8: event width in bits.
- `CLK`  in  1  clock; all logic rising-edge.
- `RSTN`  in  1  reset; asynchronous, active-low.
- `clear_i`  in  1  synchronous clear of the `overflow_o` flags (and drop counters).
- `w_en_i`  in  NCH  per-channel write strobe.
- `w_data_i`  in  NCH*M  per-channel write data; channel k occupies bits [k*M +: M].
- `full_o`  out  NCH  per-channel full.
- `empty_o`  out  NCH  per-channel empty.
- `overflow_o`  out  NCH  sticky; set when a write hits a full channel.
- `out_valid_o`  out  1  output register holds an event.
- `out_ready_i`  in  1  consumer accepts the event.
- `out_data_o`  out  M  event payload.
- `out_ch_o`  out  $clog2(NCH)  source channel of `out_data_o`.

## Operation
- Per channel: write/read addresses are $clog2(DEPTH)+1 bits wide, with the MSB as wrap bit.
  - Empty: addresses are equal.
  - Full: pointers are equal and the MSBs differ.
  - Address increments wrap naturally.
- Write: when `w_en_i[k]` is high and `full_o[k]` is low, the data is stored and the write address increments.
- Dropped write: when `w_en_i[k]` is high and `full_o[k]` is high, the data is discarded and `overflow_o[k]` is set.
- Full is evaluated on the current state. A write to a full channel is dropped even if the same channel is popped in that cycle.
- Output stage: a single register (`out_valid_o`, `out_data_o`, `out_ch_o`).
  - Load condition: `load = !out_valid_o || out_ready_i`.
  - On `load`, the arbiter grants one non-empty channel, pops its head into the register, and sets `out_valid_o`.
  - If `load` is true and no channel is non-empty, `out_valid_o` clears.
- Arbiter is round-robin.
  - Search starts at `last_grant+1` (mod NCH).
  - `last_grant` updates only on a grant.
  - Reset value of `last_grant` is NCH-1, so channel 0 has priority first.
- No bypass: a write into an empty channel is not visible to the arbiter in the same cycle.
- `out_data_o` and `out_ch_o` are stable while `out_valid_o` is high and `out_ready_i` is low.
- `clear_i` has no effect on FIFO contents or the output register.
- If `clear_i` and an overflow event occur in the same cycle, set wins.

## Timing
- Reset (async assert, synchronous to `CLK` on release) forces:
  - all addresses to 0; `empty_o` = all 1; `full_o` = 0; `overflow_o` = 0;
  - `out_valid_o` = 0; `out_data_o` = 0; `out_ch_o` = 0; `last_grant` = NCH-1.
- Reset mid-operation discards all stored events. FIFO storage array needs no reset.
- Latency from a write strobe sampled at edge t:
  - `empty_o[k]` falls after edge t;
  - `out_valid_o` rises after edge t+1, provided the output register is free and `k` wins arbitration.
- Throughput: one event per cycle with `out_ready_i` held high.
- Flag timing: `full_o` and `empty_o` update in the cycle after the causing edge. `overflow_o` sets after the edge on which the dropped write was sampled.

## Configuration
- `SPIKE_FIFO_DROP_CNT_EN` defined:
  - adds output `drop_cnt_o` (NCH*16), with channel k at bits [k*16 +: 16];
  - each counter is a 16-bit saturating count of dropped writes, reset to 0 and cleared by `clear_i`.
- Not defined: no port and no counters. All other behaviour is identical.

## Test plan
- Reset, then write 0x11 on ch0 at edge t with `out_ready_i`=1 → `out_valid_o`=1, `out_data_o`=0x11, `out_ch_o`=0 after edge t+1; `empty_o` back to all 1 after edge t+1.
- NCH=4: one write per channel in the same cycle (0xA0..0xA3), `out_ready_i`=1 → four consecutive outputs from ch0, ch1, ch2, ch3, then `out_valid_o`=0.
- `out_ready_i`=0 with output valid; write DEPTH events to ch2 → `full_o[2]`=1 after DEPTH−1 further writes; next write sets `overflow_o[2]` and is lost; releasing ready drains exactly DEPTH+1 events in order.
- Channels 0 and 1 both continuously non-empty → grants strictly alternate 0,1,0,1.
- Backpressure: toggle `out_ready_i` every cycle → no event is lost or duplicated, and data stays stable while stalled.
- With the macro defined: 3 writes to a full channel → `drop_cnt_o` for that channel = 3; `clear_i` pulse → 0 and `overflow_o` cleared.
